// File: rtl/tri_pkg.sv
// rtl/tri_pkg.sv - screen limits, setup FSM states and edge-coefficient types
package tri_pkg;

  localparam int SCREEN_W = 1280;
  localparam int SCREEN_H = 720;

  typedef enum logic [2:0] {
    IDLE,
    E0,
    E1,
    E2,
    AREA,
    OUT
  } state_t;

  typedef logic signed [16:0] edge_ab_t;
  typedef logic signed [32:0] edge_c_t;
  typedef logic signed [33:0] area_t;

endpackage

// File: rtl/minmax3.sv
// rtl/minmax3.sv - combinational min and max of three signed 16-bit values
module minmax3 (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  input  logic signed [15:0] c,
  output logic signed [15:0] min_v,
  output logic signed [15:0] max_v
);

  logic signed [15:0] ab_min, ab_max;

  always_comb begin
    ab_min = (a < b) ? a : b;
    ab_max = (a < b) ? b : a;
    min_v  = (c < ab_min) ? c : ab_min;
    max_v  = (c > ab_max) ? c : ab_max;
  end

endmodule

// File: rtl/tri_setup.sv
// rtl/tri_setup.sv - triangle setup: edge coefficients, area, clamped bounding box
// Macro BACKFACE_CULL_EN additionally drops clockwise (negative-area) triangles.
module tri_setup
  import tri_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [3:0][31:0]   v1,
  input  logic [3:0][31:0]   v2,
  input  logic [3:0][31:0]   v3,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic               obj_done_in,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [10:0]        bb_xmin,
  output logic [10:0]        bb_xmax,
  output logic [10:0]        bb_ymin,
  output logic [10:0]        bb_ymax,
  output logic [2:0][16:0]   ea,
  output logic [2:0][16:0]   eb,
  output logic [2:0][32:0]   ec,
  output logic signed [33:0] area,
  output logic [2:0][31:0]   z_out,
  output logic               obj_done_out
);

  state_t state, state_nxt;
  logic [2:0][15:0] px_r, py_r;
  logic obj_done_r, bb_empty_r, bb_empty_nxt;
  logic accept, drop;
  logic [1:0] ia, ib;
  logic signed [15:0] pxa, pya, pxb, pyb;
  logic signed [31:0] prod_ab, prod_ba;
  edge_ab_t ea_nxt, eb_nxt;
  edge_c_t ec_nxt;
  logic signed [15:0] x_lo, x_hi, y_lo, y_hi;
  logic signed [16:0] xmin_c, xmax_c, ymin_c, ymax_c;
  area_t area_sum;
  logic unused_bits;

  // Only the integer pixel part of x/y and the z word are consumed.
  assign unused_bits = ^{v1[0], v2[0], v3[0], v1[3][15:0], v1[2][15:0],
                         v2[3][15:0], v2[2][15:0], v3[3][15:0], v3[2][15:0]};

  assign accept    = valid_in && ready_out;
  assign ready_out = (state == IDLE);
  assign valid_out = (state == OUT);

  minmax3 u_mm_x (.a(px_r[0]), .b(px_r[1]), .c(px_r[2]), .min_v(x_lo), .max_v(x_hi));
  minmax3 u_mm_y (.a(py_r[0]), .b(py_r[1]), .c(py_r[2]), .min_v(y_lo), .max_v(y_hi));

  always_comb begin
    ia = 2'd0;
    ib = 2'd1;
    case (state)
      E1: begin ia = 2'd1; ib = 2'd2; end
      E2: begin ia = 2'd2; ib = 2'd0; end
      default: ;
    endcase
    pxa = px_r[ia];
    pya = py_r[ia];
    pxb = px_r[ib];
    pyb = py_r[ib];
    // One multiplier pair shared by the three edge states.
    prod_ab = 32'(pxa) * 32'(pyb);
    prod_ba = 32'(pxb) * 32'(pya);
    ea_nxt  = edge_ab_t'(pya) - edge_ab_t'(pyb);
    eb_nxt  = edge_ab_t'(pxb) - edge_ab_t'(pxa);
    ec_nxt  = edge_c_t'(prod_ab) - edge_c_t'(prod_ba);

    // Clamp at full width so far-offscreen boxes still compare correctly.
    xmin_c = x_lo[15] ? 17'sd0 : 17'(x_lo);
    ymin_c = y_lo[15] ? 17'sd0 : 17'(y_lo);
    xmax_c = (17'(x_hi) > 17'(SCREEN_W - 1)) ? 17'(SCREEN_W - 1) : 17'(x_hi);
    ymax_c = (17'(y_hi) > 17'(SCREEN_H - 1)) ? 17'(SCREEN_H - 1) : 17'(y_hi);
    bb_empty_nxt = (xmin_c > xmax_c) || (ymin_c > ymax_c);

    area_sum = area_t'($signed(ec[0])) + area_t'($signed(ec[1])) + area_t'($signed(ec[2]));
    drop = (area_sum == '0) || bb_empty_r;
`ifdef BACKFACE_CULL_EN
    drop = drop || area_sum[33];
`else
    drop = drop || 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = E0;
      E0:      state_nxt = E1;
      E1:      state_nxt = E2;
      E2:      state_nxt = AREA;
      AREA:    state_nxt = drop ? IDLE : OUT;
      OUT:     if (ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      px_r         <= '0;
      py_r         <= '0;
      obj_done_r   <= 1'b0;
      bb_empty_r   <= 1'b0;
      bb_xmin      <= '0;
      bb_xmax      <= '0;
      bb_ymin      <= '0;
      bb_ymax      <= '0;
      ea           <= '0;
      eb           <= '0;
      ec           <= '0;
      area         <= '0;
      z_out        <= '0;
      obj_done_out <= 1'b0;
    end else begin
      state        <= state_nxt;
      obj_done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            px_r       <= {v3[3][31:16], v2[3][31:16], v1[3][31:16]};
            py_r       <= {v3[2][31:16], v2[2][31:16], v1[2][31:16]};
            z_out      <= {v3[1], v2[1], v1[1]};
            obj_done_r <= obj_done_in;
          end
        end
        E0, E1, E2: begin
          ea[ia] <= ea_nxt;
          eb[ia] <= eb_nxt;
          ec[ia] <= ec_nxt;
          if (state == E0) begin
            bb_xmin    <= xmin_c[10:0];
            bb_xmax    <= xmax_c[10:0];
            bb_ymin    <= ymin_c[10:0];
            bb_ymax    <= ymax_c[10:0];
            bb_empty_r <= bb_empty_nxt;
          end
        end
        AREA:    area <= area_sum;
        default: ;
      endcase
      if (state != IDLE && state_nxt == IDLE) obj_done_out <= obj_done_r;
    end
  end

endmodule
